// File: rtl/multicycle_step_sequencer.sv
// Step sequencer for the multicycle ARM datapath: fetch, decode, then decoder-supplied execute steps.
// Optional performance counters are enabled by defining MULTICYCLE_SEQ_PERF_CNT_EN.
module multicycle_step_sequencer #(
    parameter int              CW          = 20,
    parameter int              MAX_STEPS   = 8,
    parameter int              STEP_W      = 3,
    parameter logic [CW-1:0]   FETCH_WORD  = 20'h76100,
    parameter logic [CW-1:0]   DECODE_WORD = 20'h00010,
    parameter int              MWRITE_BIT  = 19,
    parameter int              MREAD_BIT   = 17,
    parameter logic [CW-1:0]   GATE_MASK   = 20'hD0008,
    parameter int              CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [STEP_W-1:0]       total_in,
    input  logic [MAX_STEPS*CW-1:0] steps_in,
    input  logic                    mem_ready,
    output logic [CW-1:0]           ctrl,
    output logic [STEP_W-1:0]       step,
    output logic                    last_step,
    output logic                    mem_wait,
    output logic                    instr_done,
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        wait_count,
`endif
    output logic [CNT_W-1:0]        instr_count
);

    localparam logic [STEP_W-1:0] MIN_TOTAL = STEP_W'(2);
    localparam logic [STEP_W-1:0] MAX_TOTAL = STEP_W'(MAX_STEPS - 1);
    localparam logic [CW-1:0]     MEM_BITS  = (CW'(1) << MREAD_BIT) | (CW'(1) << MWRITE_BIT);

    logic [CW-1:0]     raw;
    logic [STEP_W-1:0] total_q;
    logic [STEP_W-1:0] total_clamped;
    logic              adv;

    always_comb begin
        raw = FETCH_WORD;
        if (step == STEP_W'(0)) begin
            raw = FETCH_WORD;
        end else if (step == STEP_W'(1)) begin
            raw = DECODE_WORD;
        end else begin
            raw = steps_in[int'(step)*CW +: CW];
        end
    end

    always_comb begin
        total_clamped = total_in;
        if (total_in < MIN_TOTAL) begin
            total_clamped = MIN_TOTAL;
        end else if (total_in > MAX_TOTAL) begin
            total_clamped = MAX_TOTAL;
        end
    end

    assign mem_wait   = (raw[MREAD_BIT] | raw[MWRITE_BIT]) & ~mem_ready;
    assign adv        = en & ~flush & ~mem_wait;
    assign last_step  = (step >= MIN_TOTAL) && (step == total_q);
    assign instr_done = adv & last_step;

    // While waiting on memory the strobes must stay up so the access completes.
    always_comb begin
        ctrl = raw;
        if (!en) begin
            ctrl = raw & ~GATE_MASK;
        end else if (mem_wait) begin
            ctrl = raw & ~(GATE_MASK & ~MEM_BITS);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step        <= '0;
            total_q     <= MIN_TOTAL;
            instr_count <= '0;
        end else begin
            if (flush) begin
                step <= '0;
            end else if (adv) begin
                if (last_step) begin
                    step <= '0;
                end else begin
                    step <= step + STEP_W'(1);
                end
            end
            if (adv && (step == STEP_W'(1))) begin
                total_q <= total_clamped;
            end
            if (instr_done && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            wait_count  <= '0;
        end else begin
            if (en && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (en && mem_wait && (wait_count != {CNT_W{1'b1}})) begin
                wait_count <= wait_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Scoreboard bench for multicycle_step_sequencer (MAX_STEPS=6); per-cycle expectations are queued
// as stimulus is driven and compared on the following falling edge.
module tb_multicycle_step_sequencer;

    localparam int CW     = 20;
    localparam int NSTEP  = 6;
    localparam int STEP_W = 3;
    localparam logic [CW-1:0] FETCH  = 20'h76100;
    localparam logic [CW-1:0] DECODE = 20'h00010;
    localparam logic [CW-1:0] GATE   = 20'hD0008;
    localparam logic [CW-1:0] MEMB   = 20'hA0000;

    logic                   clk;
    logic                   reset_n;
    logic                   en;
    logic                   flush;
    logic [STEP_W-1:0]      total_in;
    logic [NSTEP*CW-1:0]    steps_in;
    logic                   mem_ready;
    logic [CW-1:0]          ctrl;
    logic [STEP_W-1:0]      step;
    logic                   last_step;
    logic                   mem_wait;
    logic                   instr_done;
    logic [15:0]            instr_count;
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
    logic [15:0]            cycle_count;
    logic [15:0]            wait_count;
`endif

    logic [CW-1:0] slot [NSTEP];

    typedef struct {
        logic [STEP_W-1:0] step;
        logic [CW-1:0]     ctrl;
        logic              done;
        logic              wt;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_cyc = 0;
    int   exp_wait = 0;
    string scen = "reset";

    multicycle_step_sequencer #(
        .CW(CW), .MAX_STEPS(NSTEP), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .total_in(total_in), .steps_in(steps_in), .mem_ready(mem_ready),
        .ctrl(ctrl), .step(step), .last_step(last_step), .mem_wait(mem_wait),
        .instr_done(instr_done),
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
        .cycle_count(cycle_count), .wait_count(wait_count),
`endif
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        steps_in = '0;
        for (int k = 0; k < NSTEP; k++) steps_in[k*CW +: CW] = slot[k];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_ctrl(input logic [STEP_W-1:0] s, input logic e, input logic w);
        logic [CW-1:0] r;
        r = (s == 0) ? FETCH : (s == 1) ? DECODE : slot[s];
        if (!e)     return r & ~GATE;
        else if (w) return r & ~(GATE & ~MEMB);
        else        return r;
    endfunction

    // Drive one cycle of stimulus, queue what the DUT must show, then compare on the falling edge.
    task automatic cyc(input logic e, input logic f, input logic mr, input logic [STEP_W-1:0] tin,
                       input logic [STEP_W-1:0] es, input logic ed, input logic ew, input logic el);
        exp_t r;
        en = e; flush = f; mem_ready = mr; total_in = tin;
        sb.push_back('{step: es, ctrl: exp_ctrl(es, e, ew), done: ed, wt: ew, last: el});
        @(negedge clk);
        r = sb.pop_front();
        check({scen, ".step"},  32'(step),       32'(r.step));
        check({scen, ".ctrl"},  32'(ctrl),       32'(r.ctrl));
        check({scen, ".done"},  32'(instr_done), 32'(r.done));
        check({scen, ".wait"},  32'(mem_wait),   32'(r.wt));
        check({scen, ".last"},  32'(last_step),  32'(r.last));
        check({scen, ".count"}, 32'(instr_count), 32'(exp_cnt));
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
        check({scen, ".cycles"}, 32'(cycle_count), 32'(exp_cyc));
        check({scen, ".waits"},  32'(wait_count),  32'(exp_wait));
`endif
        if (ed) exp_cnt++;
        if (e) exp_cyc++;
        if (e && ew) exp_wait++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        slot[0] = 20'hFFFFF;
        slot[1] = 20'hFFFFF;
        for (int k = 2; k < NSTEP; k++) slot[k] = 20'h10000 | CW'(k);
        reset_n = 1'b0; en = 1'b0; flush = 1'b0; mem_ready = 1'b1; total_in = '0;
        #3;
        check("reset.step",  32'(step), 0);
        check("reset.ctrl",  32'(ctrl), 32'(FETCH & ~GATE));
        check("reset.count", 32'(instr_count), 0);
        check("reset.done",  32'(instr_done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        scen = "basic";
        cyc(1, 0, 1, 3, 0, 0, 0, 0);
        cyc(1, 0, 1, 3, 1, 0, 0, 0);
        cyc(1, 0, 1, 3, 2, 0, 0, 0);
        cyc(1, 0, 1, 3, 3, 1, 0, 1);

        scen = "clamp_lo";
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 2, 1, 0, 1);

        scen = "clamp_hi";
        cyc(1, 0, 1, 7, 0, 0, 0, 0);
        cyc(1, 0, 1, 7, 1, 0, 0, 0);
        for (int s = 2; s < 5; s++) cyc(1, 0, 1, 7, STEP_W'(s), 0, 0, 0);
        cyc(1, 0, 1, 7, 5, 1, 0, 1);

        scen = "memwait";
        slot[3] = 20'h30003;
        cyc(1, 0, 1, 3, 0, 0, 0, 0);
        cyc(1, 0, 1, 3, 1, 0, 0, 0);
        cyc(1, 0, 1, 3, 2, 0, 0, 0);
        cyc(1, 0, 0, 3, 3, 0, 1, 1);
        cyc(1, 0, 0, 3, 3, 0, 1, 1);
        cyc(1, 0, 1, 3, 3, 1, 0, 1);
        slot[3] = 20'h10003;

        scen = "fetchwait";
        cyc(1, 0, 0, 2, 0, 0, 1, 0);
        cyc(1, 0, 1, 2, 0, 0, 0, 0);
        cyc(1, 0, 1, 2, 1, 0, 0, 0);
        cyc(1, 0, 1, 2, 2, 1, 0, 1);

        scen = "stall";
        cyc(1, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 1, 4, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 4, 2, 0, 0, 0);
        cyc(1, 0, 1, 4, 2, 0, 0, 0);
        cyc(1, 0, 1, 4, 3, 0, 0, 0);
        cyc(1, 0, 1, 4, 4, 1, 0, 1);

        scen = "flush";
        slot[2] = 20'h20002;
        cyc(1, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 1, 4, 1, 0, 0, 0);
        cyc(0, 1, 0, 4, 2, 0, 1, 0);
        slot[2] = 20'h10002;
        cyc(1, 0, 1, 4, 0, 0, 0, 0);
        cyc(1, 0, 1, 4, 1, 0, 0, 0);
        cyc(1, 0, 1, 4, 2, 0, 0, 0);
        cyc(1, 0, 1, 4, 3, 0, 0, 0);
        cyc(1, 0, 1, 4, 4, 1, 0, 1);

        scen = "latch";
        cyc(1, 0, 1, 3, 0, 0, 0, 0);
        cyc(1, 0, 1, 3, 1, 0, 0, 0);
        cyc(1, 0, 1, 5, 2, 0, 0, 0);
        cyc(1, 0, 1, 5, 3, 1, 0, 1);
        cyc(1, 0, 1, 5, 0, 0, 0, 0);

        scen = "async_rst";
        cyc(1, 0, 1, 4, 1, 0, 0, 0);
        cyc(1, 0, 1, 4, 2, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.step",  32'(step), 0);
        check("async_rst.done",  32'(instr_done), 0);
        check("async_rst.count", 32'(instr_count), 0);
`ifdef MULTICYCLE_SEQ_PERF_CNT_EN
        check("async_rst.waits", 32'(wait_count), 0);
`endif
        check("sb.empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
